// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants plus the loader's op-select and FSM enums.
// Used by instr_encoder and instr_loader (optional LOADER_CHECKSUM_EN lives in the top).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;

    // Host-facing op select; codes 12-15 are deliberately left unnamed (illegal).
    typedef enum logic [3:0] {
        SEL_ADD   = 4'd0,
        SEL_SUB   = 4'd1,
        SEL_AND   = 4'd2,
        SEL_OR    = 4'd3,
        SEL_ADDU  = 4'd4,
        SEL_SUBU  = 4'd5,
        SEL_BEQ   = 4'd6,
        SEL_SW    = 4'd7,
        SEL_LW    = 4'd8,
        SEL_ADDI  = 4'd9,
        SEL_ADDIU = 4'd10,
        SEL_J     = 4'd11
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype_word(input logic [5:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational op-select to 32-bit MIPS word encoder with illegal-op flag.
// No dependence on LOADER_CHECKSUM_EN.
module instr_encoder
    import mips_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [25:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'd0;
        o_illegal = 1'b0;
        case (i_op)
            SEL_ADD:   o_word = rtype_word(i_rs, i_rt, i_rd, FN_ADD);
            SEL_SUB:   o_word = rtype_word(i_rs, i_rt, i_rd, FN_SUB);
            SEL_AND:   o_word = rtype_word(i_rs, i_rt, i_rd, FN_AND);
            SEL_OR:    o_word = rtype_word(i_rs, i_rt, i_rd, FN_OR);
            SEL_ADDU:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_ADDU);
            SEL_SUBU:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_SUBU);
            SEL_BEQ:   o_word = itype_word(OP_BEQ,   i_rs, i_rt, i_imm[15:0]);
            SEL_SW:    o_word = itype_word(OP_SW,    i_rs, i_rt, i_imm[15:0]);
            SEL_LW:    o_word = itype_word(OP_LW,    i_rs, i_rt, i_imm[15:0]);
            SEL_ADDI:  o_word = itype_word(OP_ADDI,  i_rs, i_rt, i_imm[15:0]);
            SEL_ADDIU: o_word = itype_word(OP_ADDIU, i_rs, i_rt, i_imm[15:0]);
            SEL_J:     o_word = {OP_J, i_imm};
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Streams encoded instructions into instruction memory and holds the CPU until done.
// Define LOADER_CHECKSUM_EN to add o_checksum (running XOR of written words).
//
// state    | meaning
// ST_IDLE  | after reset, waiting for i_start, CPU held
// ST_LOAD  | accepting requests, one registered write per accept
// ST_FLUSH | final registered write retiring
// ST_DONE  | session complete, CPU released, waiting for i_start
module instr_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_op,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [25:0]       i_imm,
    input  logic              i_last,
    output logic              o_memWe,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [31:0]       o_memData,
    output logic              o_cpuHold,
    output logic              o_done,
    output logic              o_full,
    output logic              o_err
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       o_checksum
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    ld_state_e         r_state;
    ld_state_e         w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [31:0]       r_memData;
    logic              r_full;
    logic              r_err;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_ready;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_slot;
    logic [ADDR_W-1:0] w_addr;

    instr_encoder u_enc (
        .i_op      (i_op),
        .i_rs      (i_rs),
        .i_rt      (i_rt),
        .i_rd      (i_rd),
        .i_imm     (i_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // Counter holds words written this session; address is offset from BASE_ADDR.
    assign w_addr      = ADDR_W'(BASE_ADDR) + ADDR_W'(r_cnt);
    assign w_last_slot = (r_cnt == CNT_W'(DEPTH - 1));

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_accept   = 1'b0;
        w_start_ok = 1'b0;
        o_done     = 1'b0;
        o_cpuHold  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_start_ok = i_start;
                if (i_start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_ready  = !r_full;
                w_accept = i_valid && !r_full;
                if (w_accept && (i_last || (!w_illegal && w_last_slot)))
                    w_next = ST_FLUSH;
            end
            ST_FLUSH: w_next = ST_DONE;
            ST_DONE: begin
                o_done     = 1'b1;
                o_cpuHold  = 1'b0;
                w_start_ok = i_start;
                if (i_start) w_next = ST_LOAD;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_memWe   <= 1'b0;
            r_memAddr <= ADDR_W'(BASE_ADDR);
            r_memData <= 32'd0;
            r_full    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_memWe <= 1'b0;
            if (w_start_ok) begin
                r_cnt  <= '0;
                r_full <= 1'b0;
                r_err  <= 1'b0;
            end else if (w_accept) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_memWe   <= 1'b1;
                    r_memAddr <= w_addr;
                    r_memData <= w_word;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    r_full    <= w_last_slot;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_checksum <= 32'd0;
        end else if (w_start_ok) begin
            r_checksum <= 32'd0;
        end else if (w_accept && !w_illegal) begin
            r_checksum <= r_checksum ^ w_word;
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign o_ready   = w_ready;
    assign o_memWe   = r_memWe;
    assign o_memAddr = r_memAddr;
    assign o_memData = r_memData;
    assign o_full    = r_full;
    assign o_err     = r_err;

endmodule
